// File: rtl/wtile_shift_reg.sv
// One weight tile of the convolution PE array: loads NCH weights from memory, then rotates
// them through the kernel tile grid via left/up/return neighbours over the x/y/X/Y loop nest.
module wtile_shift_reg #(
  parameter int unsigned NCH    = 16,
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 4,
  parameter int unsigned KX     = 3,
  parameter int unsigned KY     = 3,
  parameter int unsigned OX     = 19,
  parameter int unsigned OY     = 19,
  parameter int unsigned RD_LAT = 1,
  localparam int unsigned WW    = NCH * DW,
  localparam int unsigned XW    = (KX > 1) ? $clog2(KX) : 1,
  localparam int unsigned YW    = (KY > 1) ? $clog2(KY) : 1,
  localparam int unsigned OXW   = (OX > 1) ? $clog2(OX) : 1,
  localparam int unsigned OYW   = (OY > 1) ? $clog2(OY) : 1
) (
  input  logic           clk,
  input  logic           xrst,
  input  logic           start,
  input  logic [AW-1:0]  kaddr,
  input  logic           en,
  output logic [AW-1:0]  w_raddr,
  output logic           w_rd,
  input  logic [WW-1:0]  w_rdata,
  input  logic [WW-1:0]  left_in,
  input  logic [WW-1:0]  up_in,
  input  logic [WW-1:0]  ret_in,
  output logic [WW-1:0]  w_out,
  output logic           w_valid,
  output logic [XW-1:0]  x,
  output logic [YW-1:0]  y,
  output logic [OXW-1:0] X,
  output logic [OYW-1:0] Y,
  output logic           busy,
  output logic           finish
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [XW-1:0]  XMax   = XW'(KX - 1);
  localparam logic [YW-1:0]  YMax   = YW'(KY - 1);
  localparam logic [OXW-1:0] OxMax  = OXW'(OX - 1);
  localparam logic [OYW-1:0] OyMax  = OYW'(OY - 1);
  localparam logic [2:0]     LdLast = 3'(RD_LAT);

  logic [1:0]     state_q, state_d;
  logic [2:0]     ld_cnt_q, ld_cnt_d;
  logic [AW-1:0]  kaddr_q, kaddr_d;
  logic [WW-1:0]  w_q, w_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [OXW-1:0] xx_q, xx_d;
  logic [OYW-1:0] yy_q, yy_d;

  logic x_last, y_last, xx_last, yy_last, run_step;

  assign x_last   = (x_q == XMax);
  assign y_last   = (y_q == YMax);
  assign xx_last  = (xx_q == OxMax);
  assign yy_last  = (yy_q == OyMax);
  assign run_step = (state_q == StRun) && en;

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    kaddr_d  = kaddr_q;
    w_d      = w_q;
    x_d      = x_q;
    y_d      = y_q;
    xx_d     = xx_q;
    yy_d     = yy_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          kaddr_d  = kaddr;
          ld_cnt_d = '0;
          x_d      = '0;
          y_d      = '0;
          xx_d     = '0;
          yy_d     = '0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        // Read issued in load cycle 0; data is captured RD_LAT cycles later.
        if (ld_cnt_q == LdLast) begin
          w_d     = w_rdata;
          state_d = StRun;
        end else begin
          ld_cnt_d = ld_cnt_q + 3'd1;
        end
      end
      StRun: begin
        if (en) begin
          if (!x_last) begin
            x_d = x_q + XW'(1);
            w_d = left_in;
          end else if (!y_last) begin
            x_d = '0;
            y_d = y_q + YW'(1);
            w_d = up_in;
          end else begin
            // Window complete: weights return home and the output position advances.
            x_d = '0;
            y_d = '0;
            w_d = ret_in;
            if (!xx_last) begin
              xx_d = xx_q + OXW'(1);
            end else begin
              xx_d = '0;
              if (!yy_last) begin
                yy_d = yy_q + OYW'(1);
              end else begin
                yy_d    = '0;
                state_d = StDone;
              end
            end
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q  <= StIdle;
      ld_cnt_q <= '0;
      kaddr_q  <= '0;
      w_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      xx_q     <= '0;
      yy_q     <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      kaddr_q  <= kaddr_d;
      w_q      <= w_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xx_q     <= xx_d;
      yy_q     <= yy_d;
    end
  end

  assign w_raddr = kaddr_q;
  assign w_rd    = (state_q == StLoad) && (ld_cnt_q == 3'd0);
  assign w_out   = w_q;
  assign w_valid = (state_q == StRun);
  assign busy    = (state_q != StIdle);
  assign finish  = run_step && x_last && y_last && xx_last && yy_last;
  assign x       = x_q;
  assign y       = y_q;
  assign X       = xx_q;
  assign Y       = yy_q;

endmodule

// File: tb/tb_wtile_shift_reg.sv
// Bench for wtile_shift_reg: scoreboard on w_valid cycles plus directed load/finish/reset checks.
module tb_wtile_shift_reg;

  localparam int unsigned NCH = 16, DW = 8, AW = 4, KX = 3, KY = 3, OX = 19, OY = 19;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned WW = NCH * DW;

  localparam logic [WW-1:0] W81   = {16{8'h81}};
  localparam logic [WW-1:0] WC3   = {16{8'hC3}};
  localparam logic [WW-1:0] WBAD  = {16{8'h77}};
  localparam logic [WW-1:0] WJUNK = {16{8'h5A}};
  localparam logic [WW-1:0] L1    = {16{8'h01}};
  localparam logic [WW-1:0] U1    = {16{8'h02}};
  localparam logic [WW-1:0] R1    = {16{8'h03}};
  localparam logic [WW-1:0] L2    = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [WW-1:0] U2    = 128'h1F1E1D1C1B1A19181716151413121110;
  localparam logic [WW-1:0] R2    = 128'h2F2E2D2C2B2A29282726252423222120;

  logic          clk = 1'b0;
  logic          xrst, start, en, w_rd, w_valid, busy, finish;
  logic [AW-1:0] kaddr, w_raddr;
  logic [WW-1:0] w_rdata, left_in, up_in, ret_in, w_out;
  logic [1:0]    cx, cy;
  logic [4:0]    cxx, cyy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [WW-1:0] w;
    logic [1:0]    x;
    logic [1:0]    y;
    logic [4:0]    xx;
    logic [4:0]    yy;
  } exp_t;
  exp_t exp_q[$];

  // Run 1 expectations per RUN cycle: weight code 0=loaded,1=left,2=up,3=ret; stall at 7..10.
  int t_w[23]  = '{0,1,1,2,1,1,2,1,1,1,1,1,1,3,1,1,2,1,1,2,1,1,3};
  int t_x[23]  = '{0,1,2,0,1,2,0,1,1,1,1,1,2,0,1,2,0,1,2,0,1,2,0};
  int t_y[23]  = '{0,0,0,1,1,1,2,2,2,2,2,2,2,0,0,0,1,1,1,2,2,2,0};
  int t_xx[23] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1,1,2};

  always #5 clk = ~clk;

  wtile_shift_reg #(
    .NCH(NCH), .DW(DW), .AW(AW), .KX(KX), .KY(KY), .OX(OX), .OY(OY), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .xrst(xrst), .start(start), .kaddr(kaddr), .en(en),
    .w_raddr(w_raddr), .w_rd(w_rd), .w_rdata(w_rdata),
    .left_in(left_in), .up_in(up_in), .ret_in(ret_in),
    .w_out(w_out), .w_valid(w_valid), .x(cx), .y(cy), .X(cxx), .Y(cyy),
    .busy(busy), .finish(finish)
  );

  // Weight memory with one-cycle read latency; data is junk outside the valid cycle.
  logic          rd_d;
  logic [AW-1:0] ra_d;
  always @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      rd_d <= 1'b0;
      ra_d <= '0;
    end else begin
      rd_d <= w_rd;
      ra_d <= w_raddr;
    end
  end
  always_comb begin
    w_rdata = WJUNK;
    if (rd_d) w_rdata = (ra_d == 4'd5) ? W81 : (ra_d == 4'd9) ? WC3 : WBAD;
  end

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [WW-1:0] w, input int xi, input int yi, input int xxi,
                      input int yyi);
    exp_t e;
    e.w  = w;
    e.x  = 2'(xi);
    e.y  = 2'(yi);
    e.xx = 5'(xxi);
    e.yy = 5'(yyi);
    exp_q.push_back(e);
  endtask

  function automatic logic [WW-1:0] sel(input int code, input logic [WW-1:0] w0,
                                        input logic [WW-1:0] l, input logic [WW-1:0] u,
                                        input logic [WW-1:0] r);
    case (code)
      0: return w0;
      1: return l;
      2: return u;
      default: return r;
    endcase
  endfunction

  // Monitor: every presented weight set is compared against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (xrst && w_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_w_out", w_out, e.w);
        check("sb_x", WW'(cx), WW'(e.x));
        check("sb_y", WW'(cy), WW'(e.y));
        check("sb_X", WW'(cxx), WW'(e.xx));
        check("sb_Y", WW'(cyy), WW'(e.yy));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, n, nrd, idx;
    xrst = 1'b1; start = 1'b0; en = 1'b0; kaddr = '0;
    left_in = '0; up_in = '0; ret_in = '0;
    #2 xrst = 1'b0;
    @(negedge clk);
    check("rst_busy", WW'(busy), 0);
    check("rst_w_valid", WW'(w_valid), 0);
    check("rst_w_out", w_out, 0);
    check("rst_w_rd", WW'(w_rd), 0);
    check("rst_counters", WW'({cx, cy, cxx, cyy}), 0);
    @(posedge clk); #1 xrst = 1'b1;

    // Run 1: load from address 5, mux sequence, stall, finish with stalls included.
    @(posedge clk); #1;
    kaddr = 4'd5; en = 1'b1; left_in = L1; up_in = U1; ret_in = R1; start = 1'b1;
    for (int i = 0; i < 23; i++) push(sel(t_w[i], W81, L1, U1, R1), t_x[i], t_y[i], t_xx[i], 0);
    @(negedge clk);
    check("idle_no_rd", WW'(w_rd), 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("load_w_rd", WW'(w_rd), 1);
    check("load_w_raddr", WW'(w_raddr), 5);
    check("load_busy", WW'(busy), 1);
    @(negedge clk);
    check("load1_w_rd", WW'(w_rd), 0);
    check("load1_w_valid", WW'(w_valid), 0);
    @(negedge clk);
    check("run_w_valid", WW'(w_valid), 1);
    check("run_w_out", w_out, W81);
    repeat (7) @(posedge clk);
    #1 en = 1'b0;
    repeat (4) @(posedge clk);
    #1 en = 1'b1;
    idx = 11;
    @(negedge clk);
    while (!finish && idx < 4000) begin
      @(negedge clk);
      idx++;
    end
    check("finish_idx_stalled", WW'(idx), 3252);
    @(negedge clk);
    check("done_finish", WW'(finish), 0);
    check("done_busy", WW'(busy), 1);
    check("done_w_valid", WW'(w_valid), 0);
    check("done_w_out", w_out, R1);
    check("done_counters", WW'({cx, cy, cxx, cyy}), 0);
    @(negedge clk);
    check("idle_busy", WW'(busy), 0);

    // Run 2: start held through RUN; lane-distinct neighbours; exact run length.
    @(posedge clk); #1;
    kaddr = 4'd9; left_in = L2; up_in = U2; ret_in = R2; start = 1'b1;
    push(WC3, 0, 0, 0, 0);
    push(L2, 1, 0, 0, 0);
    push(L2, 2, 0, 0, 0);
    push(U2, 0, 1, 0, 0);
    push(L2, 1, 1, 0, 0);
    lat = 0;
    @(negedge clk);
    while (!w_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("start_to_valid", WW'(lat), 3);
    n = 0;
    nrd = 0;
    while (!finish && n < 4000) begin
      @(negedge clk);
      n++;
      if (w_rd) nrd++;
    end
    check("run_cycles", WW'(n + 1), 3249);
    check("no_reload_in_run", WW'(nrd), 0);
    @(negedge clk);
    check("done2_finish", WW'(finish), 0);
    check("done2_busy", WW'(busy), 1);
    check("done2_w_out", w_out, R2);
    @(negedge clk);
    check("idle2_busy", WW'(busy), 0);
    @(negedge clk);
    check("reload_w_rd", WW'(w_rd), 1);
    check("reload_w_raddr", WW'(w_raddr), 9);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reload_w_valid", WW'(w_valid), 1);
    check("reload_w_out", w_out, WC3);

    // Asynchronous reset in the middle of RUN.
    repeat (3) @(negedge clk);
    #1 xrst = 1'b0;
    #1;
    check("arst_w_out", w_out, 0);
    check("arst_w_valid", WW'(w_valid), 0);
    check("arst_busy", WW'(busy), 0);
    check("arst_finish", WW'(finish), 0);
    check("arst_rd_addr", WW'({w_rd, w_raddr}), 0);
    check("arst_counters", WW'({cx, cy, cxx, cyy}), 0);
    @(posedge clk); #1 xrst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", WW'(busy), 0);
    check("post_rst_w_rd", WW'(w_rd), 0);
    check("sb_drained", WW'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
